// File: rtl/decoder_scan_n_if.sv
// Bus bundle for decoder_scan_n: the DIRECT handshake, the SCAN controls and the decoded outputs.
// The master drives the controls and the slave (the decoder) drives the outputs.
interface decoder_scan_n_if #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
);
    logic                ena;
    logic                mode;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        in;
    logic [DWELL_W-1:0]  dwell;
    logic [N-1:0]        last_index;
    logic [(2**N)-1:0]   out;
    logic                out_valid;
    logic [N-1:0]        index;
    logic                wrap;

    modport master (
        output ena, mode, in_valid, in, dwell, last_index,
        input  in_ready, out, out_valid, index, wrap
    );

    modport slave (
        input  ena, mode, in_valid, in, dwell, last_index,
        output in_ready, out, out_valid, index, wrap
    );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder: DIRECT decodes a handshaked index, SCAN walks 0..last_index.
// Optional build macro DECODER_SCAN_BLANK_EN inserts one blank cycle on every SCAN index step.
module decoder_scan_n #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    decoder_scan_n_if.slave   bus
);
    localparam int OW = 2**N;
    localparam logic [N-1:0] IDX_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [OW-1:0]        r_out;
    logic [OW-1:0]        w_outNext;
    logic [N-1:0]         r_index;
    logic [N-1:0]         w_indexNext;
    logic [DWELL_W-1:0]   r_dwellCnt;
    logic [DWELL_W-1:0]   w_cntNext;
    logic                 r_wrap;
    logic                 w_wrapNext;
    logic                 w_atLast;
    logic [N-1:0]         w_stepIdx;
`ifdef DECODER_SCAN_BLANK_EN
    logic                 r_blank;
    logic                 w_blankNext;
`endif

    function automatic logic [OW-1:0] oneHot(input logic [N-1:0] idx);
        oneHot = '0;
        oneHot[idx] = 1'b1;
    endfunction

    // Using >= lets a lowered last_index wrap on the very next step.
    assign w_atLast  = (r_index >= bus.last_index);
    assign w_stepIdx = w_atLast ? '0 : r_index + IDX_ONE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_outNext   = r_out;
        w_indexNext = r_index;
        w_cntNext   = r_dwellCnt;
        w_wrapNext  = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
        w_blankNext = 1'b0;
`endif
        if (!bus.ena) begin
            w_stateNext = IDLE;
            w_outNext   = '0;
        end else if (!bus.mode) begin
            w_stateNext = DIRECT;
            if (r_state == DIRECT && bus.in_valid) begin
                w_outNext   = oneHot(bus.in);
                w_indexNext = bus.in;
            end
        end else begin
            w_stateNext = SCAN;
            if (r_state != SCAN) begin
                w_outNext   = oneHot('0);
                w_indexNext = '0;
                w_cntNext   = '0;
`ifdef DECODER_SCAN_BLANK_EN
            end else if (r_blank) begin
                w_outNext   = oneHot(r_index);
`endif
            end else if (r_dwellCnt >= bus.dwell) begin
                w_cntNext   = '0;
                w_indexNext = w_stepIdx;
                w_wrapNext  = w_atLast;
`ifdef DECODER_SCAN_BLANK_EN
                w_outNext   = '0;
                w_blankNext = 1'b1;
`else
                w_outNext   = oneHot(w_stepIdx);
`endif
            end else begin
                w_cntNext   = r_dwellCnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out      <= '0;
            r_index    <= '0;
            r_dwellCnt <= '0;
            r_wrap     <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            r_blank    <= 1'b0;
`endif
        end else begin
            r_out      <= w_outNext;
            r_index    <= w_indexNext;
            r_dwellCnt <= w_cntNext;
            r_wrap     <= w_wrapNext;
`ifdef DECODER_SCAN_BLANK_EN
            r_blank    <= w_blankNext;
`endif
        end
    end

    assign bus.in_ready  = (r_state == DIRECT) && bus.ena;
    assign bus.out       = r_out;
    assign bus.out_valid = |r_out;
    assign bus.index     = r_index;
    assign bus.wrap      = r_wrap;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Table-driven bench for decoder_scan_n (N=4, DWELL_W=8) with hand-computed expected outputs.
// Each table row is one clock: inputs applied, then outputs checked 1ns after the rising edge.
module tb_decoder_scan_n;
    logic clk;
    logic rst;

    decoder_scan_n_if #(.N(4), .DWELL_W(8)) bus ();

    decoder_scan_n #(.N(4), .DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        ena;
        logic        mode;
        logic        vld;
        logic [3:0]  in;
        logic [7:0]  dwell;
        logic [3:0]  last;
        logic [15:0] expOut;
        logic [3:0]  expIdx;
        logic        expWrap;
        logic        expRdy;
    } vec_t;

    vec_t vecs[$];
    int   vectorCount;
    int   missCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic r, input logic e, input logic m, input logic v,
                                   input logic [3:0] i, input logic [7:0] d, input logic [3:0] l,
                                   input logic [15:0] eo, input logic [3:0] ei,
                                   input logic ew, input logic er);
        vec_t t;
        t.rst = r; t.ena = e; t.mode = m; t.vld = v; t.in = i; t.dwell = d; t.last = l;
        t.expOut = eo; t.expIdx = ei; t.expWrap = ew; t.expRdy = er;
        return t;
    endfunction

    task automatic addVec(input logic r, input logic e, input logic m, input logic v,
                          input logic [3:0] i, input logic [7:0] d, input logic [3:0] l,
                          input logic [15:0] eo, input logic [3:0] ei,
                          input logic ew, input logic er);
        vecs.push_back(mkVec(r, e, m, v, i, d, l, eo, ei, ew, er));
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        bus.ena        = v.ena;
        bus.mode       = v.mode;
        bus.in_valid   = v.vld;
        bus.in         = v.in;
        bus.dwell      = v.dwell;
        bus.last_index = v.last;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        logic expValid;
        expValid = |v.expOut;
        vectorCount++;
        if (bus.out !== v.expOut) begin
            missCount++;
            $display("[TB] FAIL %s out: got %h, expected %h", tag, bus.out, v.expOut);
        end
        if (bus.out_valid !== expValid) begin
            missCount++;
            $display("[TB] FAIL %s out_valid: got %b, expected %b", tag, bus.out_valid, expValid);
        end
        if (bus.index !== v.expIdx) begin
            missCount++;
            $display("[TB] FAIL %s index: got %0d, expected %0d", tag, bus.index, v.expIdx);
        end
        if (bus.wrap !== v.expWrap) begin
            missCount++;
            $display("[TB] FAIL %s wrap: got %b, expected %b", tag, bus.wrap, v.expWrap);
        end
        if (bus.in_ready !== v.expRdy) begin
            missCount++;
            $display("[TB] FAIL %s in_ready: got %b, expected %b", tag, bus.in_ready, v.expRdy);
        end
    endtask

    initial begin
        vec_t v;
        vectorCount = 0;
        missCount   = 0;
        rst = 1'b0;
        bus.ena = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0;
        bus.in = '0; bus.dwell = '0; bus.last_index = '0;

        //     rst ena mode vld in    dwell  last   expOut     idx   wrap rdy
        addVec(0,  1,  1,   0,  4'h0, 8'd0,  4'd0,  16'h0000,  4'd0,  0,  0);
        addVec(0,  1,  1,   0,  4'h0, 8'd0,  4'd0,  16'h0000,  4'd0,  0,  0);
        addVec(1,  1,  0,   0,  4'h0, 8'd0,  4'd0,  16'h0000,  4'd0,  0,  1);
        addVec(1,  1,  0,   1,  4'hB, 8'd0,  4'd0,  16'h0800,  4'd11, 0,  1);
        addVec(1,  1,  0,   0,  4'h3, 8'd0,  4'd0,  16'h0800,  4'd11, 0,  1);
        addVec(1,  1,  0,   1,  4'h0, 8'd0,  4'd0,  16'h0001,  4'd0,  0,  1);
        addVec(1,  1,  0,   1,  4'hF, 8'd0,  4'd0,  16'h8000,  4'd15, 0,  1);
        addVec(1,  0,  0,   1,  4'h2, 8'd0,  4'd0,  16'h0000,  4'd15, 0,  0);
        addVec(1,  1,  0,   1,  4'h5, 8'd0,  4'd0,  16'h0000,  4'd15, 0,  1);
        addVec(1,  1,  0,   1,  4'h5, 8'd0,  4'd0,  16'h0020,  4'd5,  0,  1);
`ifdef DECODER_SCAN_BLANK_EN
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0000,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0000,  4'd0,  1,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0000,  4'd1,  0,  0);
        addVec(1,  0,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0000,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd1,  16'h0001,  4'd0,  0,  0);
`else
        // SCAN dwell=2 last=3: three cycles per index, wrap on the 3 -> 0 step.
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0004,  4'd2,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0004,  4'd2,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0004,  4'd2,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0008,  4'd3,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0008,  4'd3,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0008,  4'd3,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0001,  4'd0,  1,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0004,  4'd2,  0,  0);
        // ena dropped at index 2, then restored: restart at index 0.
        addVec(1,  0,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0000,  4'd2,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd2,  4'd3,  16'h0001,  4'd0,  0,  0);
        // dwell=0 last=0: index stays 0, wrap every cycle.
        addVec(1,  1,  1,   0,  4'h0, 8'd0,  4'd0,  16'h0001,  4'd0,  1,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd0,  4'd0,  16'h0001,  4'd0,  1,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd0,  4'd0,  16'h0001,  4'd0,  1,  0);
        // last_index lowered below the current index wraps on the next step.
        addVec(1,  1,  1,   0,  4'h0, 8'd0,  4'd7,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd0,  4'd7,  16'h0004,  4'd2,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd0,  4'd7,  16'h0008,  4'd3,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd0,  4'd1,  16'h0001,  4'd0,  1,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd0,  4'd1,  16'h0002,  4'd1,  0,  0);
        // SCAN -> DIRECT keeps the scanned value until the first transfer.
        addVec(1,  1,  0,   1,  4'h9, 8'd0,  4'd1,  16'h0002,  4'd1,  0,  1);
        addVec(1,  1,  0,   1,  4'h9, 8'd0,  4'd1,  16'h0200,  4'd9,  0,  1);
        // dwell lowered below the running count steps immediately.
        addVec(1,  1,  1,   0,  4'h0, 8'd5,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd5,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd5,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd5,  4'd3,  16'h0001,  4'd0,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd3,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd3,  16'h0002,  4'd1,  0,  0);
        addVec(1,  1,  1,   0,  4'h0, 8'd1,  4'd3,  16'h0004,  4'd2,  0,  0);
`endif

        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec%0d", k), vecs[k]);
        end

        // Synchronous reset in the middle of activity wins over ena/mode.
        v = mkVec(0, 1, 0, 1, 4'h7, 8'd0, 4'd3, 16'h0000, 4'd0, 0, 0);
        applyStimulus(v);
        checkOutput("midReset", v);
        v = mkVec(1, 1, 0, 1, 4'h7, 8'd0, 4'd3, 16'h0000, 4'd0, 0, 1);
        applyStimulus(v);
        checkOutput("postResetFirst", v);
        v = mkVec(1, 1, 0, 1, 4'h7, 8'd0, 4'd3, 16'h0080, 4'd7, 0, 1);
        applyStimulus(v);
        checkOutput("postResetXfer", v);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
